bram_stream_reader: RTL and testbench

Read-side sequencer placed directly downstream of the true dual-port block RAM in the Eyeriss buffer path. It accepts a (base, length) read command, issues one port-A read per cycle, tracks the RAM's fixed read latency, and presents the returned words as a valid/ready stream toward the PE array. A small credit-controlled FIFO absorbs back-pressure so no returned word is ever lost. The RAM's port A is owned exclusively by this block; port B stays with the writer.

---
 rtl/bram_stream_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side sequencer for the buffer's true dual-port block RAM. Accepts a
// (base, length) read command, issues one port-A read per cycle, tags each
// read through the RAM's fixed read latency, and presents the returned words
// as a valid/ready stream. A small output FIFO absorbs back-pressure. Reads
// are only issued while a FIFO slot is guaranteed for the returning word, so
// no word is ever lost.
//
// Configuration macro:
//   BRAM_RD_LOW_LATENCY_EN  defined   -> RD_LAT = 1 (RAM built LOW_LATENCY)
//                           undefined -> RD_LAT = 2 (RAM built HIGH_PERFORMANCE)
//
// Ports:
//   clk          in   single clock, also the RAM's clka
//   rst          in   synchronous, active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  command accepted when high together with cmd_valid
//   cmd_base     in   [ADDR_W]   first word address
//   cmd_len      in   [ADDR_W+1] word count, 0..2^ADDR_W
//   bram_ena     out  RAM port-A enable, one read per high cycle
//   bram_wea     out  tied 0 (port A is read-only here)
//   bram_addra   out  [ADDR_W]   RAM port-A address
//   bram_regcea  out  tied 1 (RAM output register always enabled)
//   bram_douta   in   [DATA_W]   RAM port-A read data
//   m_valid      out  stream word available
//   m_ready      in   downstream accepts
//   m_data       out  [DATA_W]   stream word
//   m_last       out  high with the final word of a command
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse at command completion
// -----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic              bram_regcea,
    input  logic [DATA_W-1:0] bram_douta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

`ifdef BRAM_RD_LOW_LATENCY_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 2;
`endif

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // Sequencer state
    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remaining;

    // Return path: one tag per outstanding RAM read, shifted in lock-step
    // with the RAM pipeline so the tag exits exactly when the data is valid.
    logic [RD_LAT-1:0]   r_tag_vld;
    logic [RD_LAT-1:0]   r_tag_last;
    logic [CNT_W-1:0]    r_inflight;

    // Output FIFO
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic                r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [SUM_W-1:0]    w_used;
    logic                w_credit;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;
    logic                w_head_last;

    // A read may only be issued if its word is guaranteed a FIFO slot:
    // every read not yet popped (in the RAM pipe or sitting in the FIFO)
    // holds one credit.
    assign w_used       = SUM_W'(r_inflight) + SUM_W'(r_count);
    assign w_credit     = (w_used < SUM_W'(FIFO_DEPTH));
    assign w_issue      = (r_state == ISSUE) && w_credit;
    assign w_last_issue = (r_remaining == LEN_W'(1));
    assign w_push       = r_tag_vld[RD_LAT-1];
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && m_ready;
    assign w_head_last  = r_fifo_last[r_rd_ptr];

    // -------------------------------------------------------------------------
    // Command sequencer
    // -------------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_base;
                        r_remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            // Empty command completes without touching the RAM.
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        // Address wraps naturally at 2^ADDR_W.
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last word can only be handshaken here: it leaves
                    // the RAM at least RD_LAT cycles after the final issue.
                    if (w_pop && w_head_last) begin
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Return-path tags, credit counters and FIFO pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Clearing the tags drops any RAM data still in flight.
            r_tag_vld  <= '0;
            r_tag_last <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_tag_vld[0]  <= w_issue;
            r_tag_last[0] <= w_issue && w_last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end

            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is never read
    // before it is written because m_valid derives from the reset count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bram_douta;
            r_fifo_last[r_wr_ptr] <= r_tag_last[RD_LAT-1];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready   = r_cmd_ready;
    assign bram_ena    = w_issue;
    assign bram_wea    = 1'b0;
    assign bram_addra  = r_addr;
    assign bram_regcea = 1'b1;
    assign m_valid     = w_valid;
    assign m_data      = r_fifo_data[r_rd_ptr];
    assign m_last      = w_valid && w_head_last;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Scoreboard bench for bram_stream_reader. A behavioural RAM model sits on
// port A. The stimulus process pushes the expected word stream of each
// command (computed from base/len and the RAM contents) into a queue when it
// offers the command; an independent monitor on the falling edge pops and
// compares every handshaken word and also tracks issue credits, addresses,
// first-word latency, done timing and stream stability.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_DEPTH  = 1 << ADDR_W;

`ifdef BRAM_RD_LOW_LATENCY_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic              bram_regcea;
    logic [DATA_W-1:0] bram_douta;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    bram_stream_reader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .bram_ena    (bram_ena),
        .bram_wea    (bram_wea),
        .bram_addra  (bram_addra),
        .bram_regcea (bram_regcea),
        .bram_douta  (bram_douta),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- RAM model
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] ram_q2;

    always @(posedge clk) begin
        if (bram_ena) ram_q <= ram[bram_addra];
        if (bram_regcea) ram_q2 <= ram_q;
    end

`ifdef BRAM_RD_LOW_LATENCY_EN
    assign bram_douta = ram_q;
`else
    assign bram_douta = ram_q2;
`endif

    // -------------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_expect(input logic [ADDR_W-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data = ram[(int'(base) + i) % RAM_DEPTH];
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
    endfunction

    // ------------------------------------------------------- m_ready driver
    // 0: always ready, 1: repeating 1-0-0-1, 2: random
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph  = (rdy_ph + 1) % 4;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ----------------------------------------------------------------- monitor
    int                outstanding = 0;  // reads issued but not yet popped
    int                iss_left    = 0;
    logic [ADDR_W-1:0] iss_addr    = '0;
    bit                done_due    = 1'b0;
    int                lat_target  = -1;
    bit                prev_stall  = 1'b0;
    logic [DATA_W-1:0] prev_data   = '0;
    bit                expect_strm = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            iss_left    = 0;
            done_due    = 1'b0;
            lat_target  = -1;
            prev_stall  = 1'b0;
            expect_strm = 1'b0;
        end else begin
            // done exactly one cycle after the final handshake / empty accept
            if (done || done_due) begin
                check("done", 32'(done), 32'(done_due));
                if (done_due) check("busy_in_done_cycle", 32'(busy), 0);
            end
            done_due = 1'b0;

            if (busy && cmd_valid) check("cmd_ready_while_busy", 32'(cmd_ready), 0);

            if (lat_target >= 0) begin
                if (cyc == lat_target - 1) check("m_valid_early", 32'(m_valid), 0);
                if (cyc == lat_target) begin
                    check("first_word_latency", 32'(m_valid), 1);
                    lat_target = -1;
                end
            end

            if (prev_stall) begin
                check("valid_held_on_stall", 32'(m_valid), 1);
                check("data_held_on_stall", 32'(m_data), 32'(prev_data));
            end
            if (expect_strm) check("no_bubble", 32'(m_valid), 1);
            expect_strm = 1'b0;

            // Issue whenever words remain and a FIFO credit is free.
            if (iss_left > 0 || bram_ena) begin
                check("bram_ena", 32'(bram_ena), 32'((iss_left > 0) && (outstanding < FIFO_DEPTH)));
                if (bram_ena) begin
                    check("bram_addra", 32'(bram_addra), 32'(iss_addr));
                    iss_addr = iss_addr + 1'b1;
                    iss_left--;
                    outstanding++;
                end
            end

            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", m_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(e.data));
                    check("m_last", 32'(m_last), 32'(e.last));
                    if (e.last) done_due = 1'b1;
                    else if (rdy_mode == 0) expect_strm = 1'b1;
                end
                outstanding--;
            end

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;

            if (cmd_valid && cmd_ready) begin
                if (cmd_len == '0) begin
                    done_due = 1'b1;
                end else begin
                    lat_target = cyc + 2 + RD_LAT;
                    iss_addr   = cmd_base;
                    iss_left   = int'(cmd_len);
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic print_summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    task automatic wait_accept();
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        do begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 8000);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic send_cmd(input logic [ADDR_W-1:0] base, input int len);
        cmd_base  = base;
        cmd_len   = (ADDR_W + 1)'(len);
        cmd_valid = 1'b1;
        push_expect(base, len);
        wait_accept();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while ((exp_q.size() != 0 || busy || m_valid) && n < 8000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 8000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < RAM_DEPTH; a++) ram[a] = DATA_W'(a);

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bram_ena", 32'(bram_ena), 0);
        check("rst_bram_addra", 32'(bram_addra), 0);
        check("rst_m_last", 32'(m_last), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("bram_wea", 32'(bram_wea), 0);
        check("bram_regcea", 32'(bram_regcea), 1);

        // Straight burst, ready held high
        rdy_mode = 0;
        send_cmd(10'h010, 8);
        wait_idle();

        // Address wrap at the top of the RAM
        send_cmd(10'h3FE, 4);
        wait_idle();

        // Back-pressure pattern 1-0-0-1
        rdy_mode = 1;
        send_cmd(10'h100, 16);
        wait_idle();
        rdy_mode = 0;

        // Empty command
        send_cmd(10'h055, 0);
        wait_idle();

        // Reset two cycles into issuing
        send_cmd(10'h000, 8);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_cmd_ready", 32'(cmd_ready), 1);
        send_cmd(10'h020, 2);
        wait_idle();

        // Second command held while the first is active
        send_cmd(10'h030, 5);
        cmd_base  = 10'h040;
        cmd_len   = 11'd3;
        cmd_valid = 1'b1;
        push_expect(10'h040, 3);
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();

        // Randomized commands against random RAM contents and random ready
        for (int a = 0; a < RAM_DEPTH; a++) ram[a] = DATA_W'($urandom);
        rdy_mode = 2;
        send_cmd(10'($urandom_range(0, RAM_DEPTH - 1)), 1);
        wait_idle();
        send_cmd(10'($urandom_range(0, RAM_DEPTH - 1)), RAM_DEPTH);
        wait_idle();
        for (int k = 0; k < 30; k++) begin
            send_cmd(10'($urandom_range(RAM_DEPTH - 24, RAM_DEPTH - 1) + (k % 2) * 300),
                     int'($urandom_range(0, 24)));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        rdy_mode = 0;

        print_summary();
        $finish;
    end

    // Global bound so a stuck design still produces a summary.
    initial begin
        #(60000 * 10);
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
        print_summary();
        $finish;
    end

endmodule
